// File: rtl/uart_pkg.sv
// uart_pkg: shared parity mode constants and transmitter FSM state type
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy count
// ports: clk_tx/rst, wr_en/wr_data push side, rd_en/rd_data pop side (rd_data shows head),
//        count occupancy, full/empty flags
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_tx,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk_tx) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk_tx) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter fed from a small character FIFO
// ports: clk_tx/rst, in_valid/in_ready/data_in character input, data_out serial line (idle high),
//        busy while a frame is on the line, fifo_count queued characters
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FREQUENCY   = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_tx,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          data_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BAUD_DIV = FREQUENCY / BAUD;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic HAS_PAR = PARITY_MODE != PAR_NONE;

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_cfg: FREQUENCY/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t state, state_nx;
    logic [BW-1:0] baud_cnt, baud_nx;
    logic [3:0] bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shift, shift_nx, rd_data;
    logic par, par_nx, dout_nx, pop, launch, bit_end, full, empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk_tx  (clk_tx),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready = !full;
    assign busy     = state != IDLE;
    assign bit_end  = baud_cnt == BAUD_LAST;

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            data_out <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            shift    <= shift_nx;
            par      <= par_nx;
            data_out <= dout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + BW'(1);
        bit_nx   = bit_cnt;
        shift_nx = shift;
        par_nx   = par;
        dout_nx  = data_out;
        launch   = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                baud_nx = '0;
                dout_nx = 1'b1;
                launch  = !empty;
            end
            START: if (bit_end) begin
                state_nx = DATA;
                baud_nx  = '0;
                bit_nx   = '0;
                dout_nx  = shift[0];
                shift_nx = shift >> 1;
            end
            DATA: if (bit_end) begin
                baud_nx = '0;
                if (bit_cnt == DATA_LAST) begin
                    bit_nx   = '0;
                    state_nx = HAS_PAR ? PARITY : STOP;
                    dout_nx  = HAS_PAR ? par : 1'b1;
                end else begin
                    bit_nx   = bit_cnt + 4'd1;
                    dout_nx  = shift[0];
                    shift_nx = shift >> 1;
                end
            end
            PARITY: if (bit_end) begin
                state_nx = STOP;
                baud_nx  = '0;
                dout_nx  = 1'b1;
            end
            STOP: if (bit_end) begin
                baud_nx = '0;
                if (bit_cnt == STOP_LAST) begin
                    state_nx = IDLE;
                    dout_nx  = 1'b1;
                    launch   = !empty;
                end else begin
                    bit_nx = bit_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // The pop cycle loads the shifter and drives the start bit on the next edge,
        // so a waiting character follows the last stop bit with no idle gap.
        if (launch) begin
            pop      = 1'b1;
            state_nx = START;
            baud_nx  = '0;
            bit_nx   = '0;
            dout_nx  = 1'b0;
            shift_nx = rd_data;
            par_nx   = (^rd_data) ^ (PARITY_MODE == PAR_ODD);
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;
    localparam int DIV = 10;
    logic clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    logic a_rst, bc_rst;
    logic a_valid, b_valid, c_valid;
    logic [7:0] a_data, c_data;
    logic [6:0] b_data;
    logic a_ready, b_ready, c_ready;
    logic a_dout, b_dout, c_dout;
    logic a_busy, b_busy, c_busy;
    logic [2:0] a_cnt, b_cnt, c_cnt;
    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] q [5];

    uart_tx_cfg #(.FREQUENCY(1_000_000), .BAUD(100_000)) dut_a (
        .clk_tx(clk_tx), .rst(a_rst), .in_valid(a_valid), .in_ready(a_ready), .data_in(a_data),
        .data_out(a_dout), .busy(a_busy), .fifo_count(a_cnt));
    uart_tx_cfg #(.FREQUENCY(1_000_000), .BAUD(100_000), .PARITY_MODE(2), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .clk_tx(clk_tx), .rst(bc_rst), .in_valid(b_valid), .in_ready(b_ready), .data_in(b_data),
        .data_out(b_dout), .busy(b_busy), .fifo_count(b_cnt));
    uart_tx_cfg #(.FREQUENCY(1_000_000), .BAUD(100_000), .PARITY_MODE(0)) dut_c (
        .clk_tx(clk_tx), .rst(bc_rst), .in_valid(c_valid), .in_ready(c_ready), .data_in(c_data),
        .data_out(c_dout), .busy(c_busy), .fifo_count(c_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_dout(input int d);
        return d == 0 ? a_dout : d == 1 ? b_dout : c_dout;
    endfunction

    function automatic logic sel_busy(input int d);
        return d == 0 ? a_busy : d == 1 ? b_busy : c_busy;
    endfunction

    // 8-bit even-parity frame, LSB = start bit
    function automatic logic [15:0] frame_even8(input logic [7:0] d);
        return {5'b0, 1'b1, ^d, d, 1'b0};
    endfunction

    // Called at the falling edge of cycle 'skip' of the start bit; checks every cycle of the frame.
    task automatic check_frame(input int d, input logic [15:0] bits, input int nbits, input int skip, input string tag);
        for (int c = skip; c < nbits * DIV; c++) begin
            chk($sformatf("%s_bit%0d_cyc%0d", tag, c / DIV, c % DIV), 32'(sel_dout(d)), 32'(bits[c / DIV]));
            chk($sformatf("%s_busy_cyc%0d", tag, c), 32'(sel_busy(d)), 32'd1);
            @(negedge clk_tx);
        end
    endtask

    initial begin
        q = '{8'h11, 8'h22, 8'h3C, 8'h80, 8'hFE};
        a_rst = 1'b1; bc_rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
        a_data = 8'h77; b_data = 7'h55; c_data = 8'h33;
        repeat (3) @(negedge clk_tx);
        chk("rst_a_dout", 32'(a_dout), 32'd1);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_dout", 32'(b_dout), 32'd1);
        chk("rst_b_cnt", 32'(b_cnt), 32'd0);
        chk("rst_c_dout", 32'(c_dout), 32'd1);
        chk("rst_c_cnt", 32'(c_cnt), 32'd0);
        a_rst = 1'b0; bc_rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        @(negedge clk_tx);
        chk("idle_a_dout", 32'(a_dout), 32'd1);
        chk("idle_a_busy", 32'(a_busy), 32'd0);

        a_valid = 1'b1; a_data = 8'hA5;
        @(negedge clk_tx);
        a_valid = 1'b0;
        chk("a5_pop_cycle_dout", 32'(a_dout), 32'd1);
        chk("a5_pop_cycle_busy", 32'(a_busy), 32'd0);
        chk("a5_queued", 32'(a_cnt), 32'd1);
        @(negedge clk_tx);
        check_frame(0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0, "a5");
        chk("a5_end_dout", 32'(a_dout), 32'd1);
        chk("a5_end_busy", 32'(a_busy), 32'd0);
        chk("a5_end_cnt", 32'(a_cnt), 32'd0);

        b_valid = 1'b1; b_data = 7'h41;
        @(negedge clk_tx);
        b_valid = 1'b0;
        @(negedge clk_tx);
        check_frame(1, {5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, 11, 0, "b41");
        chk("b41_end_dout", 32'(b_dout), 32'd1);
        chk("b41_end_busy", 32'(b_busy), 32'd0);

        c_valid = 1'b1; c_data = 8'hFF;
        @(negedge clk_tx);
        c_data = 8'h00;
        @(negedge clk_tx);
        c_valid = 1'b0;
        chk("c_simul_push_pop_cnt", 32'(c_cnt), 32'd1);
        check_frame(2, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 0, "cff");
        check_frame(2, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 0, "c00");
        chk("c_end_dout", 32'(c_dout), 32'd1);
        chk("c_end_busy", 32'(c_busy), 32'd0);
        chk("c_end_cnt", 32'(c_cnt), 32'd0);

        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1; a_data = q[i];
            @(negedge clk_tx);
        end
        chk("b2b_full_ready", 32'(a_ready), 32'd0);
        chk("b2b_full_cnt", 32'(a_cnt), 32'd4);
        a_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_tx);
            chk("full_hold_ready", 32'(a_ready), 32'd0);
            chk("full_hold_cnt", 32'(a_cnt), 32'd4);
        end
        a_valid = 1'b0;
        check_frame(0, frame_even8(q[0]), 11, 8, "b2b0");
        for (int i = 1; i < 5; i++) check_frame(0, frame_even8(q[i]), 11, 0, $sformatf("b2b%0d", i));
        chk("b2b_end_dout", 32'(a_dout), 32'd1);
        chk("b2b_end_busy", 32'(a_busy), 32'd0);
        chk("b2b_end_cnt", 32'(a_cnt), 32'd0);
        chk("b2b_end_ready", 32'(a_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_data = q[i];
            @(negedge clk_tx);
        end
        a_valid = 1'b0;
        chk("abort_queued", 32'(a_cnt), 32'd3);
        repeat (30) @(negedge clk_tx);
        chk("abort_mid_data_busy", 32'(a_busy), 32'd1);
        chk("abort_mid_data_dout", 32'(a_dout), 32'(q[0][2]));
        a_rst = 1'b1; a_valid = 1'b1; a_data = 8'h5A;
        @(negedge clk_tx);
        a_rst = 1'b0; a_valid = 1'b0;
        chk("abort_dout", 32'(a_dout), 32'd1);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_cnt", 32'(a_cnt), 32'd0);
        chk("abort_ready", 32'(a_ready), 32'd1);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_tx);
            chk("after_abort_dout", 32'(a_dout), 32'd1);
            chk("after_abort_busy", 32'(a_busy), 32'd0);
        end
        chk("after_abort_cnt", 32'(a_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
